// File: rtl/xbar_ingress.sv
// Per-slave-port crossbar ingress: buffers a packet stream in a small FIFO,
// pins the destination for a whole packet and discards packets to absent masters.
module xbar_ingress #(
  parameter int DATA_W    = 32,
  parameter int DEST_W    = 2,
  parameter int N_MASTERS = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int ENT_W  = DATA_W + 1 + DEST_W;
  localparam logic [DEST_W:0] NM = (DEST_W + 1)'(N_MASTERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_DROP
  } state_e;

  state_e              state_q, state_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                active_q;
  logic [ENT_W-1:0]    mem_q [DEPTH];

  logic                full;
  logic                empty;
  logic                accept;
  logic                pop;
  logic                dest_ok;
  logic                push;
  logic                drop_hit;
  logic [DEST_W-1:0]   wr_dest;
  logic [ENT_W-1:0]    head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full     = (count_q == FILL_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign dest_ok  = ({1'b0, in_dest} < NM);
  // active_q keeps in_ready low while reset is held, without a combinational rst_n path.
  assign in_ready = active_q && (!full || (state_q == S_DROP));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Sequencer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !in_last) begin
          state_d = dest_ok ? S_FWD : S_DROP;
        end
      end
      S_FWD, S_DROP: begin
        if (accept && in_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer: outputs (store strobe, stored dest, drop event)
  always_comb begin
    push     = 1'b0;
    wr_dest  = dest_q;
    drop_hit = 1'b0;
    dest_d   = dest_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dest_ok) begin
            push    = 1'b1;
            wr_dest = in_dest;
            dest_d  = in_dest;
          end else begin
            drop_hit = in_last;
          end
        end
      end
      S_FWD:   push     = accept;
      S_DROP:  drop_hit = accept && in_last;
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + FILL_W'(1);
      2'b01:   count_d = count_q - FILL_W'(1);
      default: count_d = count_q;
    endcase
    drop_cnt_d = drop_hit ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      dest_q     <= dest_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      active_q   <= 1'b1;
    end
  end

  // FIFO storage: payload only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_data, in_last, wr_dest};
    end
  end

  // Outputs are forced to zero when empty so reset presents a clean idle bus.
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign out_data  = out_valid ? head[ENT_W-1 -: DATA_W] : '0;
  assign out_last  = out_valid && head[DEST_W];
  assign out_dest  = out_valid ? head[DEST_W-1:0] : '0;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_xbar_ingress.sv
// Scoreboard bench for xbar_ingress: packet-level reference model feeds an
// expected-beat queue; an independent monitor checks every popped beat.
module tb_xbar_ingress;

  localparam int DATA_W    = 32;
  localparam int DEST_W    = 2;
  localparam int N_MASTERS = 3;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 3;
  localparam int CNT_MAX   = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic [DEST_W-1:0] in_dest;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [DEST_W-1:0] out_dest;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  drop_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
    logic [DEST_W-1:0] dest;
  } beat_t;

  beat_t exp_q[$];
  int    vectors    = 0;
  int    miscompares = 0;
  int    exp_drops  = 0;
  int    accepts    = 0;
  int    ready_mode = 0;
  int    beats_sent = 0;
  bit    pkt_done;

  xbar_ingress #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .N_MASTERS(N_MASTERS),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold on stalls.
  initial begin : monitor
    bit    stall;
    beat_t held;
    beat_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_beat", 64'({out_data, out_last, out_dest}), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t",
                     {out_data, out_last, out_dest}, $time);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", 64'({out_data, out_last, out_dest}), 64'(e));
          end
        end
        stall = out_valid && !out_ready;
        held  = {out_data, out_last, out_dest};
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] dst,
                           input logic last, input bit exp_rdy, input bit stored);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_dest  = dst;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (t == 0 && exp_rdy) chk("drop_in_ready", 64'(in_ready), 64'(1));
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      accepts++;
      beats_sent++;
      if (stored) chk("valid_after_push", 64'(out_valid), 64'(1));
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
    end
    in_valid = 1'b0;
  endtask

  // dmode: 0 = same dest every beat, 1 = zero after first beat, 2 = random after first
  task automatic send_pkt(input int len, input logic [DEST_W-1:0] d0, input int dmode,
                          input bit gaps);
    logic [DATA_W-1:0] dv [8];
    logic [DEST_W-1:0] dd [8];
    bit                drop;
    beat_t             b;
    drop = (int'(d0) >= N_MASTERS);
    for (int i = 0; i < len; i++) begin
      dv[i] = $urandom;
      if (i == 0 || dmode == 0) dd[i] = d0;
      else if (dmode == 1)      dd[i] = '0;
      else                      dd[i] = DEST_W'($urandom_range(0, 3));
    end
    if (drop) begin
      if (exp_drops < CNT_MAX) exp_drops++;
    end else begin
      for (int i = 0; i < len; i++) begin
        b.d    = dv[i];
        b.l    = (i == len - 1);
        b.dest = d0;
        exp_q.push_back(b);
      end
    end
    for (int i = 0; i < len; i++) begin
      send_beat(dv[i], dd[i], (i == len - 1), drop && i > 0, !drop);
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    ready_mode = 0;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    chk("idle_valid", 64'(out_valid), 64'(0));
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_dest", 64'(out_dest), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet dest=1, always ready; checks latency, dest, last, order
    ready_mode = 0;
    chk("pre_valid", 64'(out_valid), 64'(0));
    send_pkt(3, 2'd1, 0, 1'b0);
    drain();

    // dest changes 1,0,0 inside the packet; all beats keep dest 1
    send_pkt(3, 2'd1, 1, 1'b0);
    drain();

    // stalled output, 5-beat packet into 4-deep FIFO
    ready_mode = 1;
    @(posedge clk);
    #1;
    a0       = accepts;
    pkt_done = 1'b0;
    fork
      begin
        send_pkt(5, 2'd1, 0, 1'b0);
        pkt_done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk);
    chk("full_accepts", 64'(accepts - a0), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_valid", 64'(out_valid), 64'(1));
    ready_mode = 0;
    for (int t = 0; t < 100 && !pkt_done; t++) @(negedge clk);
    chk("full_pkt_done", 64'(pkt_done), 64'(1));
    wait (pkt_done);
    drain();

    // dropped 2-beat packet to dest 3, then 1-beat packet to dest 2
    send_pkt(2, 2'd3, 0, 1'b0);
    send_pkt(1, 2'd2, 0, 1'b0);
    drain();

    // random traffic with random backpressure
    ready_mode = 2;
    beats_sent = 0;
    while (beats_sent < 120) begin
      send_pkt($urandom_range(1, 4), DEST_W'($urandom_range(0, 3)),
               (($urandom_range(0, 1) == 1) ? 2 : 0), 1'b1);
    end
    drain();

    // drop counter saturation
    for (int i = 0; i < CNT_MAX + 2; i++) send_pkt(1, 2'd3, 0, 1'b0);
    drain();
    chk("drop_sat", 64'(drop_cnt), 64'(CNT_MAX));

    // reset mid-packet with two beats buffered
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_beat(32'hA5A5_0001, 2'd1, 1'b0, 1'b0, 1'b1);
    send_beat(32'hA5A5_0002, 2'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_mode = 0;
    send_pkt(1, 2'd3, 0, 1'b0);
    send_pkt(2, 2'd0, 0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
